// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave memory with configurable wait states, byte-lane writes and pipelined transfers.
// Define AHB_SLV_ERR_EN to give out-of-range, oversize and misaligned transfers an ERROR response.
module ahb_slave_mem #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DEPTH       = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic [1:0]        HRESP,
  output logic [DATA_W-1:0] HRDATA
);
  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF   = $clog2(NB);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

  state_e            r_state, w_state_d;
  logic [3:0]        r_cnt, w_cnt_d;
  logic              r_write;
  logic [IDX_W-1:0]  r_idx;
  logic [NB-1:0]     r_lanes;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_can_accept, w_accept, w_illegal;
  logic [ADDR_W-1:0] w_off, w_word;
  logic [2:0]        w_size;
  logic [OFF-1:0]    w_amask, w_boff;
  logic [NB-1:0]     w_lanes;
  logic              w_unused;

  assign w_can_accept = (r_state == StIdle) || (r_state == StData) || (r_state == StErr2);
  assign w_accept     = HSEL && HREADY && HTRANS[1] && w_can_accept;
  assign w_off        = HADDR - BASE_ADDR;
  assign w_word       = w_off >> OFF;
  // Oversize transfers collapse to a full-width access.
  assign w_size       = (HSIZE > 3'(OFF)) ? 3'(OFF) : HSIZE;

  always_comb begin
    w_amask = '0;
    for (int unsigned b = 0; b < OFF; b++) w_amask[b] = (b < 32'(w_size));
    w_boff  = HADDR[OFF-1:0] & ~w_amask;
    w_lanes = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      w_lanes[b] = (b >= 32'(w_boff)) && (b < 32'(w_boff) + (32'd1 << w_size));
    end
  end

`ifdef AHB_SLV_ERR_EN
  assign w_illegal = (HADDR < BASE_ADDR) || ((w_word >> IDX_W) != '0) ||
                     (HSIZE > 3'(OFF)) || ((HADDR[OFF-1:0] & w_amask) != '0);
`else
  assign w_illegal = 1'b0;
`endif

  assign w_unused = ^{HBURST, HTRANS[0], w_word};

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    case (r_state)
      StWait: begin
        if (r_cnt == '0) w_state_d = StData;
        else w_cnt_d = r_cnt - 4'd1;
      end
      StErr1:  w_state_d = StErr2;
      default: ;
    endcase
    if (w_accept) begin
      if (w_illegal) begin
        w_state_d = StErr1;
      end else if (WAIT_STATES != 0) begin
        w_state_d = StWait;
        w_cnt_d   = 4'(WAIT_STATES - 1);
      end else begin
        w_state_d = StData;
      end
    end else if (w_can_accept) begin
      w_state_d = StIdle;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_idx   <= '0;
      r_lanes <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (w_accept) begin
        r_write <= HWRITE;
        r_idx   <= w_word[IDX_W-1:0];
        r_lanes <= w_lanes;
      end
    end
  end

  // Async read: a read whose data phase follows a write to the same word sees the committed lanes.
  always_ff @(posedge HCLK) begin
    if (r_state == StData && r_write) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (r_lanes[b]) r_mem[r_idx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HREADYOUT = !((r_state == StWait) || (r_state == StErr1));
  assign HRDATA    = (r_state == StData && !r_write) ? r_mem[r_idx] : '0;

`ifdef AHB_SLV_ERR_EN
  assign HRESP = ((r_state == StErr1) || (r_state == StErr2)) ? 2'b01 : 2'b00;
`else
  assign HRESP = 2'b00;
`endif

endmodule
